// File: rtl/memory_stage_unit_pkg.sv
// Shared types and widths for the memory stage: access kinds, sizes,
// FSM states and the entry captured while an access is outstanding.
package memory_stage_unit_pkg;

    localparam int WORD       = 32;
    localparam int ADDR_WIDTH = 5;

    typedef logic reg_file_write_sig;
    localparam reg_file_write_sig REG_WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        SRC_ALU       = 2'd0,
        SRC_MEM       = 2'd1,
        SRC_PC_PLUS_4 = 2'd2
    } reg_file_data_source;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } mem_stage_state_t;

    // Everything about an instruction that must survive a multi-cycle access
    typedef struct packed {
        mem_op_t                 op;
        mem_size_t               size;
        logic                    load_signed;
        reg_file_write_sig       we;
        reg_file_data_source     src;
        logic [ADDR_WIDTH-1:0]   rd;
        logic [WORD-1:0]         addr;
        logic [WORD-1:0]         sdata;
    } mem_entry_t;

endpackage

// File: rtl/memory_stage_unit_mem_lane_align.sv
// Little-endian lane steering: store data replication and byte enables,
// load lane extraction with zero/sign extension, and misalignment detection.
module mem_lane_align
    import memory_stage_unit_pkg::*;
(
    input  mem_size_t        size_i,
    input  logic [1:0]       addr_lo_i,
    input  logic [WORD-1:0]  store_data_i,
    input  logic [WORD-1:0]  rdata_i,
    input  logic             load_signed_i,
    output logic [WORD-1:0]  wdata_o,
    output logic [3:0]       be_o,
    output logic [WORD-1:0]  load_data_o,
    output logic             misaligned_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Store lanes and alignment check depend only on size and the low address bits
    always_comb begin
        wdata_o      = store_data_i;
        be_o         = 4'b1111;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                wdata_o = {4{store_data_i[7:0]}};
                be_o    = 4'b0001 << addr_lo_i;
            end
            SZ_HALF: begin
                wdata_o      = {2{store_data_i[15:0]}};
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_lo_i[0];
            end
            default: begin
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

    // Load lane selection followed by zero or sign extension
    always_comb begin
        lane_b      = rdata_i[{addr_lo_i, 3'b000} +: 8];
        lane_h      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        load_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: load_data_o = {{24{load_signed_i & lane_b[7]}}, lane_b};
            SZ_HALF: load_data_o = {{16{load_signed_i & lane_h[15]}}, lane_h};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_stage_unit.sv
// Memory stage: takes EX/MEM fields, runs loads/stores over a valid/ready
// request and valid-only response, and registers the MEM/WB fields.
module memory_stage_unit
    import memory_stage_unit_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    is_valid_i,
    input  mem_op_t                 mem_op_i,
    input  mem_size_t               mem_size_i,
    input  logic                    load_signed_i,
    input  reg_file_write_sig       reg_file_write_en_i,
    input  reg_file_data_source     reg_file_data_source_i,
    input  logic [ADDR_WIDTH-1:0]   reg_dest_addr_i,
    input  logic [WORD-1:0]         alu_result_i,
    input  logic [WORD-1:0]         reg_2_data_i,
    output logic                    stall_o,
    output logic                    dmem_req_valid_o,
    input  logic                    dmem_req_ready_i,
    output logic                    dmem_we_o,
    output logic [WORD-1:0]         dmem_addr_o,
    output logic [WORD-1:0]         dmem_wdata_o,
    output logic [3:0]              dmem_be_o,
    input  logic                    dmem_rsp_valid_i,
    input  logic [WORD-1:0]         dmem_rdata_i,
    output logic                    is_valid_o,
    output reg_file_write_sig       reg_file_write_en_o,
    output reg_file_data_source     reg_file_data_source_o,
    output logic [ADDR_WIDTH-1:0]   reg_dest_addr_o,
    output logic [WORD-1:0]         alu_result_o,
    output logic [WORD-1:0]         mem_data_o,
    output logic                    fault_o
);

    mem_stage_state_t      state_q, state_d;
    mem_entry_t            ent_q, ent_d;

    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
    reg_file_write_sig     we_q, we_d;
    reg_file_data_source   src_q, src_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [WORD-1:0]       alu_q, alu_d;
    logic [WORD-1:0]       mdata_q, mdata_d;

    mem_size_t             lane_size;
    logic [1:0]            lane_addr_lo;
    logic [WORD-1:0]       lane_wdata;
    logic [3:0]            lane_be;
    logic [WORD-1:0]       lane_load;
    logic                  lane_mis;
    logic                  in_req;

    // In IDLE the aligner vets the incoming instruction; otherwise it serves the captured one
    assign lane_size    = (state_q == IDLE) ? mem_size_i         : ent_q.size;
    assign lane_addr_lo = (state_q == IDLE) ? alu_result_i[1:0]  : ent_q.addr[1:0];

    mem_lane_align u_align (
        .size_i        (lane_size),
        .addr_lo_i     (lane_addr_lo),
        .store_data_i  (ent_q.sdata),
        .rdata_i       (dmem_rdata_i),
        .load_signed_i (ent_q.load_signed),
        .wdata_o       (lane_wdata),
        .be_o          (lane_be),
        .load_data_o   (lane_load),
        .misaligned_o  (lane_mis)
    );

    // Request fields come straight from the captured entry, so they stay stable across REQ
    assign in_req           = (state_q == REQ);
    assign stall_o          = (state_q != IDLE);
    assign dmem_req_valid_o = in_req;
    assign dmem_we_o        = in_req && (ent_q.op == MEM_STORE);
    assign dmem_addr_o      = in_req ? {ent_q.addr[WORD-1:2], 2'b00} : '0;
    assign dmem_wdata_o     = in_req ? lane_wdata : '0;
    assign dmem_be_o        = in_req ? lane_be    : 4'b0000;

    assign is_valid_o             = valid_q;
    assign fault_o                = fault_q;
    assign reg_file_write_en_o    = we_q;
    assign reg_file_data_source_o = src_q;
    assign reg_dest_addr_o        = rd_q;
    assign alu_result_o           = alu_q;
    assign mem_data_o             = mdata_q;

    // Next state, captured entry and MEM/WB fields; outputs only pulse valid on completion
    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        valid_d = 1'b0;
        fault_d = fault_q;
        we_d    = we_q;
        src_d   = src_q;
        rd_d    = rd_q;
        alu_d   = alu_q;
        mdata_d = mdata_q;
        case (state_q)
            IDLE: begin
                if (is_valid_i) begin
                    if ((mem_op_i == MEM_NONE) || lane_mis) begin
                        valid_d = 1'b1;
                        fault_d = (mem_op_i != MEM_NONE);
                        we_d    = (mem_op_i != MEM_NONE) ? REG_WRITE_DISABLE : reg_file_write_en_i;
                        src_d   = reg_file_data_source_i;
                        rd_d    = reg_dest_addr_i;
                        alu_d   = alu_result_i;
                        mdata_d = '0;
                    end else begin
                        ent_d.op          = mem_op_i;
                        ent_d.size        = mem_size_i;
                        ent_d.load_signed = load_signed_i;
                        ent_d.we          = reg_file_write_en_i;
                        ent_d.src         = reg_file_data_source_i;
                        ent_d.rd          = reg_dest_addr_i;
                        ent_d.addr        = alu_result_i;
                        ent_d.sdata       = reg_2_data_i;
                        state_d           = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_req_ready_i) begin
                    if (ent_q.op == MEM_STORE) begin
                        state_d = IDLE;
                        valid_d = 1'b1;
                        fault_d = 1'b0;
                        we_d    = ent_q.we;
                        src_d   = ent_q.src;
                        rd_d    = ent_q.rd;
                        alu_d   = ent_q.addr;
                        mdata_d = '0;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (dmem_rsp_valid_i) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    fault_d = 1'b0;
                    we_d    = ent_q.we;
                    src_d   = ent_q.src;
                    rd_d    = ent_q.rd;
                    alu_d   = ent_q.addr;
                    mdata_d = lane_load;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and MEM/WB registers; reset abandons any access and clears every output
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            we_q    <= REG_WRITE_DISABLE;
            src_q   <= SRC_ALU;
            rd_q    <= '0;
            alu_q   <= '0;
            mdata_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            we_q    <= we_d;
            src_q   <= src_d;
            rd_q    <= rd_d;
            alu_q   <= alu_d;
            mdata_q <= mdata_d;
        end
    end

    // Captured entry is pure data and is only consumed while the FSM is out of IDLE
    always_ff @(posedge clk_i) begin
        ent_q <= ent_d;
    end

endmodule

// File: tb/tb_memory_stage_unit.sv
// Bench for memory_stage_unit: directed scenarios followed by randomized
// traffic against a memory responder and a transaction-level reference model.
module tb_memory_stage_unit;
    import memory_stage_unit_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_i;
    logic                  is_valid_i;
    mem_op_t               mem_op_i;
    mem_size_t             mem_size_i;
    logic                  load_signed_i;
    reg_file_write_sig     reg_file_write_en_i;
    reg_file_data_source   reg_file_data_source_i;
    logic [ADDR_WIDTH-1:0] reg_dest_addr_i;
    logic [WORD-1:0]       alu_result_i;
    logic [WORD-1:0]       reg_2_data_i;
    logic                  stall_o;
    logic                  dmem_req_valid_o;
    logic                  dmem_req_ready_i;
    logic                  dmem_we_o;
    logic [WORD-1:0]       dmem_addr_o;
    logic [WORD-1:0]       dmem_wdata_o;
    logic [3:0]            dmem_be_o;
    logic                  dmem_rsp_valid_i;
    logic [WORD-1:0]       dmem_rdata_i;
    logic                  is_valid_o;
    reg_file_write_sig     reg_file_write_en_o;
    reg_file_data_source   reg_file_data_source_o;
    logic [ADDR_WIDTH-1:0] reg_dest_addr_o;
    logic [WORD-1:0]       alu_result_o;
    logic [WORD-1:0]       mem_data_o;
    logic                  fault_o;

    always #5 clk = ~clk;

    memory_stage_unit dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .is_valid_i             (is_valid_i),
        .mem_op_i               (mem_op_i),
        .mem_size_i             (mem_size_i),
        .load_signed_i          (load_signed_i),
        .reg_file_write_en_i    (reg_file_write_en_i),
        .reg_file_data_source_i (reg_file_data_source_i),
        .reg_dest_addr_i        (reg_dest_addr_i),
        .alu_result_i           (alu_result_i),
        .reg_2_data_i           (reg_2_data_i),
        .stall_o                (stall_o),
        .dmem_req_valid_o       (dmem_req_valid_o),
        .dmem_req_ready_i       (dmem_req_ready_i),
        .dmem_we_o              (dmem_we_o),
        .dmem_addr_o            (dmem_addr_o),
        .dmem_wdata_o           (dmem_wdata_o),
        .dmem_be_o              (dmem_be_o),
        .dmem_rsp_valid_i       (dmem_rsp_valid_i),
        .dmem_rdata_i           (dmem_rdata_i),
        .is_valid_o             (is_valid_o),
        .reg_file_write_en_o    (reg_file_write_en_o),
        .reg_file_data_source_o (reg_file_data_source_o),
        .reg_dest_addr_o        (reg_dest_addr_o),
        .alu_result_o           (alu_result_o),
        .mem_data_o             (mem_data_o),
        .fault_o                (fault_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        sgn;
        logic        we;
        logic [1:0]  src;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] data;
        int          acc_cyc;
    } instr_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    instr_t exp_q[$];
    instr_t req_q[$];

    // memory responder controls and bookkeeping
    bit          rand_mem = 1'b0;
    int          ready_lat = 0;
    int          rsp_lat = 0;
    int          req_cnt = 0;
    int          rsp_cnt = 0;
    bit          rsp_pending = 1'b0;
    bit          rsp_real = 1'b0;
    logic [31:0] rsp_word = '0;
    int          last_hs_cyc = 0;
    int          last_rsp_cyc = 0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_be;
    logic        prev_we;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Backing memory contents, indexed by word
    function automatic logic [31:0] rom(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & ~32'd3;
        if (wa == 32'h200) return 32'h80FF_0000;
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit model_fault(input instr_t t);
        int nb;
        nb = 1 << t.size;
        return (t.op != 2'd0) && ((t.addr % nb) != 0);
    endfunction

    function automatic logic [31:0] model_load(input instr_t t);
        int          nb;
        logic [31:0] w, v, mask;
        nb = 1 << t.size;
        w  = rom(t.addr);
        if (nb == 4) return w;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = (w >> (8 * (t.addr % 4))) & mask;
        if (t.sgn && (v > (mask >> 1))) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] model_be(input instr_t t);
        int nb;
        nb = 1 << t.size;
        return ((32'd1 << nb) - 32'd1) << (t.addr % 4);
    endfunction

    function automatic logic [31:0] model_wdata(input instr_t t);
        if (t.size == 2'd2) return t.data;
        if (t.size == 2'd1) return (t.data & 32'hFFFF) * 32'h0001_0001;
        return (t.data & 32'hFF) * 32'h0101_0101;
    endfunction

    // Observes request handshakes and completions at the falling edge
    task automatic monitor_step();
        instr_t t;
        bit     flt;
        int     exp_cyc;
        if (dmem_req_valid_o) begin
            if (prev_wait) begin
                check_eq("req_stable_addr", dmem_addr_o, prev_addr);
                check_eq("req_stable_be", 32'(dmem_be_o), 32'(prev_be));
                check_eq("req_stable_we", 32'(dmem_we_o), 32'(prev_we));
                check_eq("req_stable_wdata", dmem_wdata_o, prev_wdata);
            end
            if (dmem_req_ready_i) begin
                prev_wait = 1'b0;
                check_eq("req_expected", 32'(req_q.size() != 0), 32'd1);
                if (req_q.size() != 0) begin
                    t = req_q.pop_front();
                    check_eq("req_addr", dmem_addr_o, t.addr & ~32'd3);
                    check_eq("req_be", 32'(dmem_be_o), model_be(t));
                    check_eq("req_we", 32'(dmem_we_o), 32'(t.op == 2'd2));
                    if (t.op == 2'd2) check_eq("req_wdata", dmem_wdata_o, model_wdata(t));
                    else begin
                        rsp_pending = 1'b1;
                        rsp_cnt     = 0;
                        rsp_word    = rom(t.addr);
                    end
                end
                last_hs_cyc = cyc;
            end else begin
                prev_wait  = 1'b1;
                prev_addr  = dmem_addr_o;
                prev_be    = dmem_be_o;
                prev_we    = dmem_we_o;
                prev_wdata = dmem_wdata_o;
            end
        end else begin
            prev_wait = 1'b0;
        end
        if (dmem_rsp_valid_i && rsp_real) last_rsp_cyc = cyc;
        if (is_valid_o) begin
            check_eq("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                t   = exp_q.pop_front();
                flt = model_fault(t);
                check_eq("out_fault", 32'(fault_o), 32'(flt));
                check_eq("out_we", 32'(reg_file_write_en_o), flt ? 32'd0 : 32'(t.we));
                check_eq("out_src", 32'(reg_file_data_source_o), 32'(t.src));
                check_eq("out_rd", 32'(reg_dest_addr_o), 32'(t.rd));
                check_eq("out_alu", alu_result_o, t.addr);
                if (t.op == 2'd1 && !flt) check_eq("out_mem_data", mem_data_o, model_load(t));
                if (t.op == 2'd0 || flt) exp_cyc = t.acc_cyc + 1;
                else if (t.op == 2'd2)   exp_cyc = last_hs_cyc + 1;
                else                     exp_cyc = last_rsp_cyc + 1;
                check_eq("out_latency", cyc, exp_cyc);
            end
        end
    endtask

    // Drives ready/response for the next cycle just after the rising edge
    task automatic mem_step();
        if (dmem_rsp_valid_i) begin
            dmem_rsp_valid_i = 1'b0;
            rsp_real         = 1'b0;
        end else if (rsp_pending) begin
            if (rand_mem ? ($urandom_range(0, 2) == 0) : (rsp_cnt >= rsp_lat)) begin
                dmem_rsp_valid_i = 1'b1;
                rsp_real         = 1'b1;
                rsp_pending      = 1'b0;
            end else begin
                rsp_cnt++;
            end
        end else if (rand_mem && ($urandom_range(0, 7) == 0)) begin
            dmem_rsp_valid_i = 1'b1;
            rsp_real         = 1'b0;
        end
        dmem_rdata_i = rsp_real ? rsp_word : $urandom;
        if (dmem_req_valid_o) begin
            dmem_req_ready_i = rand_mem ? ($urandom_range(0, 2) != 0) : (req_cnt >= ready_lat);
            req_cnt++;
        end else begin
            dmem_req_ready_i = rand_mem ? 1'($urandom_range(0, 1)) : 1'b0;
            req_cnt = 0;
        end
    endtask

    initial begin
        dmem_req_ready_i = 1'b0;
        dmem_rsp_valid_i = 1'b0;
        dmem_rdata_i     = '0;
        forever begin
            @(negedge clk);
            if (!reset_i) monitor_step();
            @(posedge clk);
            #1;
            mem_step();
        end
    end

    // Presents one instruction and holds it until the stage takes it
    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                         input logic we, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] data);
        instr_t t;
        bit     accepted;
        accepted               = 1'b0;
        is_valid_i             = 1'b1;
        mem_op_i               = mem_op_t'(op);
        mem_size_i             = mem_size_t'(size);
        load_signed_i          = sgn;
        reg_file_write_en_i    = we;
        reg_file_data_source_i = reg_file_data_source'(src);
        reg_dest_addr_i        = rd;
        alu_result_i           = addr;
        reg_2_data_i           = data;
        t.op = op; t.size = size; t.sgn = sgn; t.we = we; t.src = src;
        t.rd = rd; t.addr = addr; t.data = data;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!stall_o) begin
                t.acc_cyc = cyc;
                exp_q.push_back(t);
                if (op != 2'd0 && !model_fault(t)) req_q.push_back(t);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        check_eq("accept", 32'(accepted), 32'd1);
    endtask

    task automatic idle(input int n);
        is_valid_i   = 1'b0;
        mem_op_i     = mem_op_t'(2'($urandom_range(0, 2)));
        alu_result_i = $urandom;
        reg_2_data_i = $urandom;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 500; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        idle(2);
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_is_valid"}, 32'(is_valid_o), 32'd0);
        check_eq({tag, "_stall"}, 32'(stall_o), 32'd0);
        check_eq({tag, "_req_valid"}, 32'(dmem_req_valid_o), 32'd0);
        check_eq({tag, "_fault"}, 32'(fault_o), 32'd0);
        check_eq({tag, "_we"}, 32'(reg_file_write_en_o), 32'd0);
        check_eq({tag, "_alu"}, alu_result_o, 32'd0);
        check_eq({tag, "_mem_data"}, mem_data_o, 32'd0);
        check_eq({tag, "_rd"}, 32'(reg_dest_addr_o), 32'd0);
        check_eq({tag, "_src"}, 32'(reg_file_data_source_o), 32'd0);
        check_eq({tag, "_dmem_we"}, 32'(dmem_we_o), 32'd0);
        check_eq({tag, "_dmem_addr"}, dmem_addr_o, 32'd0);
        check_eq({tag, "_dmem_wdata"}, dmem_wdata_o, 32'd0);
        check_eq({tag, "_dmem_be"}, 32'(dmem_be_o), 32'd0);
    endtask

    initial begin
        reset_i                = 1'b1;
        is_valid_i             = 1'b0;
        mem_op_i               = MEM_NONE;
        mem_size_i             = SZ_WORD;
        load_signed_i          = 1'b0;
        reg_file_write_en_i    = 1'b0;
        reg_file_data_source_i = SRC_ALU;
        reg_dest_addr_i        = '0;
        alu_result_i           = '0;
        reg_2_data_i           = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Non-memory op passes through in one cycle without stalling
        issue(2'd0, 2'd2, 1'b0, 1'b1, 2'd0, 5'd3, 32'h1234_5678, 32'h0);
        idle(0);
        @(negedge clk);
        check_eq("none_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        drain();

        // Store byte to the top lane, memory ready immediately
        ready_lat = 0;
        issue(2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 5'd4, 32'h0000_0103, 32'h1234_56AB);
        idle(0);
        drain();

        // Signed half load from the upper half with a slow memory
        ready_lat = 3;
        rsp_lat   = 2;
        issue(2'd1, 2'd1, 1'b1, 1'b1, 2'd1, 5'd5, 32'h0000_0202, 32'h0);
        idle(0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (is_valid_o) break;
            check_eq("ld_stall", 32'(stall_o), 32'd1);
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        drain();

        // Misaligned word load traps without touching memory
        issue(2'd1, 2'd2, 1'b0, 1'b1, 2'd1, 5'd7, 32'h0000_0006, 32'h0);
        idle(0);
        drain();

        // Load followed immediately by a non-memory op that must wait
        ready_lat = 0;
        rsp_lat   = 0;
        issue(2'd1, 2'd2, 1'b0, 1'b1, 2'd1, 5'd8, 32'h0000_0300, 32'h0);
        issue(2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 5'd9, 32'hCAFE_0001, 32'h0);
        idle(0);
        drain();

        // Reset while waiting for a response; the late response must be ignored
        ready_lat = 0;
        rsp_lat   = 4;
        issue(2'd1, 2'd0, 1'b0, 1'b1, 2'd1, 5'd10, 32'h0000_0041, 32'h0);
        idle(1);
        check_eq("pre_reset_stall", 32'(stall_o), 32'd1);
        reset_i = 1'b1;
        exp_q.delete();
        req_q.delete();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check_quiet("midreset");
        @(posedge clk);
        #1;
        idle(10);
        check_eq("post_reset_stall", 32'(stall_o), 32'd0);
        check_eq("post_reset_rsp_done", 32'(rsp_pending), 32'd0);

        // Randomized traffic with random memory timing and spurious responses
        rand_mem = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'($urandom),
                  1'($urandom), 2'($urandom_range(0, 2)), 5'($urandom),
                  32'($urandom_range(0, 32'hFFF)), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(0);
        drain();
        rand_mem = 1'b0;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
